// File: rtl/branch_rs.sv
// Branch reservation station: a collapsing queue of branch/jump instructions
// that tracks two source operands per entry, wakes them up from the CDB and
// issues the oldest fully ready entry (one per cycle) to the branch unit.
// Optional build macro: BRANCH_RS_CDB_BYPASS_EN -- when defined, an entry whose
// missing operand(s) are being broadcast on the CDB this cycle may issue in the
// same cycle, with cdb_value forwarded into issue_insn.

package branch_rs_pkg;
    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 5;
    localparam int FUNC_W      = 4;

    localparam logic [FUNC_W-1:0] FUNC_BEQ  = 4'd0;
    localparam logic [FUNC_W-1:0] FUNC_BNE  = 4'd1;
    localparam logic [FUNC_W-1:0] FUNC_BLT  = 4'd4;
    localparam logic [FUNC_W-1:0] FUNC_BGE  = 4'd5;
    localparam logic [FUNC_W-1:0] FUNC_BLTU = 4'd6;
    localparam logic [FUNC_W-1:0] FUNC_BGEU = 4'd7;
    localparam logic [FUNC_W-1:0] FUNC_JAL  = 4'd8;
    localparam logic [FUNC_W-1:0] FUNC_JALR = 4'd9;

    // Instruction bundle exchanged with dispatch and the branch unit
    typedef struct packed {
        logic [FUNC_W-1:0]      func;
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        imm;
        logic [ROB_TAG_LEN-1:0] insn_tag;
        logic [XLEN-1:0]        value_src1;
        logic [XLEN-1:0]        value_src2;
    } INST_RS;

    // One station slot
    typedef struct packed {
        logic                   valid;
        logic [FUNC_W-1:0]      func;
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        imm;
        logic [ROB_TAG_LEN-1:0] insn_tag;
        logic                   src1_ready;
        logic [ROB_TAG_LEN-1:0] src1_tag;
        logic [XLEN-1:0]        src1_value;
        logic                   src2_ready;
        logic [ROB_TAG_LEN-1:0] src2_tag;
        logic [XLEN-1:0]        src2_value;
    } rs_entry_t;
endpackage

module branch_rs
    import branch_rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   dispatch_valid,
    input  INST_RS                 dispatch_insn,
    input  logic                   dispatch_src1_ready,
    input  logic                   dispatch_src2_ready,
    input  logic [ROB_TAG_LEN-1:0] dispatch_src1_tag,
    input  logic [ROB_TAG_LEN-1:0] dispatch_src2_tag,
    output logic                   dispatch_ready,
    input  logic                   cdb_valid,
    input  logic [ROB_TAG_LEN-1:0] cdb_tag,
    input  logic [XLEN-1:0]        cdb_value,
    output logic                   issue_en,
    output INST_RS                 issue_insn,
    output logic [CNT_W-1:0]       free_count
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    rs_entry_t              entry_reg  [NUM_ENTRIES];
    rs_entry_t              entry_next [NUM_ENTRIES];
    rs_entry_t              woken      [NUM_ENTRIES];
    rs_entry_t              new_entry;
    logic [CNT_W-1:0]       count_reg;
    logic [CNT_W-1:0]       count_next;
    logic [NUM_ENTRIES-1:0] src1_hit;
    logic [NUM_ENTRIES-1:0] src2_hit;
    logic [NUM_ENTRIES-1:0] eligible;
    logic                   sel_found;
    logic [IDX_W-1:0]       sel_idx;
    logic                   accept;
    logic [CNT_W-1:0]       write_pos;

    // Per-entry CDB tag match and select eligibility
    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            assign src1_hit[gi] = cdb_valid && !entry_reg[gi].src1_ready
                                  && (entry_reg[gi].src1_tag == cdb_tag);
            assign src2_hit[gi] = cdb_valid && !entry_reg[gi].src2_ready
                                  && (entry_reg[gi].src2_tag == cdb_tag);
`ifdef BRANCH_RS_CDB_BYPASS_EN
            assign eligible[gi] = entry_reg[gi].valid
                                  && (entry_reg[gi].src1_ready || src1_hit[gi])
                                  && (entry_reg[gi].src2_ready || src2_hit[gi]);
`else
            assign eligible[gi] = entry_reg[gi].valid
                                  && entry_reg[gi].src1_ready
                                  && entry_reg[gi].src2_ready;
`endif
        end
    endgenerate

    // Entry contents after applying this cycle's CDB wakeup
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            woken[i] = entry_reg[i];
            if (src1_hit[i]) begin
                woken[i].src1_ready = 1'b1;
                woken[i].src1_value = cdb_value;
            end
            if (src2_hit[i]) begin
                woken[i].src2_ready = 1'b1;
                woken[i].src2_value = cdb_value;
            end
        end
    end

    // Oldest-first select: lowest eligible index wins
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_en       = sel_found && !flush && !reset;
    assign dispatch_ready = (count_reg < CNT_W'(NUM_ENTRIES));
    assign free_count     = CNT_W'(NUM_ENTRIES) - count_reg;
    assign accept         = dispatch_valid && dispatch_ready && !flush;
    assign write_pos      = count_reg - CNT_W'(issue_en);

    // Issue bundle; woken values carry the forwarded CDB result in bypass builds
    always_comb begin
        issue_insn = '0;
        if (issue_en) begin
            issue_insn.func       = woken[sel_idx].func;
            issue_insn.pc         = woken[sel_idx].pc;
            issue_insn.imm        = woken[sel_idx].imm;
            issue_insn.insn_tag   = woken[sel_idx].insn_tag;
            issue_insn.value_src1 = woken[sel_idx].src1_value;
            issue_insn.value_src2 = woken[sel_idx].src2_value;
        end
    end

    // Incoming dispatch, capturing a same-cycle CDB broadcast for waiting sources
    always_comb begin
        new_entry            = '0;
        new_entry.valid      = 1'b1;
        new_entry.func       = dispatch_insn.func;
        new_entry.pc         = dispatch_insn.pc;
        new_entry.imm        = dispatch_insn.imm;
        new_entry.insn_tag   = dispatch_insn.insn_tag;
        new_entry.src1_tag   = dispatch_src1_tag;
        new_entry.src2_tag   = dispatch_src2_tag;
        new_entry.src1_ready = dispatch_src1_ready
                               || (cdb_valid && (dispatch_src1_tag == cdb_tag));
        new_entry.src2_ready = dispatch_src2_ready
                               || (cdb_valid && (dispatch_src2_tag == cdb_tag));
        new_entry.src1_value = dispatch_src1_ready ? dispatch_insn.value_src1 : cdb_value;
        new_entry.src2_value = dispatch_src2_ready ? dispatch_insn.value_src2 : cdb_value;
    end

    // Next state: wakeup, collapse above the issued slot, then append the dispatch
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            entry_next[i] = woken[i];
        end
        if (issue_en) begin
            for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) begin
                    entry_next[i] = woken[i + 1];
                end
            end
            entry_next[NUM_ENTRIES-1].valid = 1'b0;
        end
        if (accept) begin
            entry_next[write_pos[IDX_W-1:0]] = new_entry;
        end
        count_next = count_reg - CNT_W'(issue_en) + CNT_W'(accept);
    end

    // State register; reset and flush both empty the station
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry_reg[i].valid <= 1'b0;
            end
            count_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry_reg[i] <= entry_next[i];
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: doc/branch_rs.md
# branch_rs

Reservation station for the branch functional unit. Buffers dispatched branch/jump instructions (BEQ…BGEU, JAL, JALR) and tracks their two source operands. Snoops the CDB to wake up waiting operands, then issues the oldest fully ready entry, one per cycle, to the combinational branch unit. The issue outputs are the branch unit's `insn` and `en` inputs. The whole station is cleared on a pipeline flush.

## Interface
Parameters:
- `NUM_ENTRIES`, default 4: station depth; ≥2.
- `CNT_W`, default `$clog2(NUM_ENTRIES+1)`: width of `free_count`.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the `clock` rising edge.
- `flush`  in  1  squash all entries (misprediction recovery).
- `dispatch_valid`  in  1  dispatch request.
- `dispatch_insn`  in  INST_RS  fields used: `func`, `pc`, `imm`, `insn_tag`, `value_src1`, `value_src2` (a value field is meaningful only when the matching ready bit is set).
- `dispatch_src1_ready`, `dispatch_src2_ready`  in  1 each  operand already available.
- `dispatch_src1_tag`, `dispatch_src2_tag`  in  `ROB_TAG_LEN` each  producer tag when not ready.
- `dispatch_ready`  out  1  station can accept a dispatch this cycle.
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb_tag`  in  `ROB_TAG_LEN`  broadcast producer tag.
- `cdb_value`  in  `XLEN`  broadcast result.
- `issue_en`  out  1  drives branch unit `en`.
- `issue_insn`  out  INST_RS  drives branch unit `insn`; fields other than the six listed above are zero.
- `free_count`  out  `CNT_W`  number of invalid entries.

## Operation
Each entry holds:
- valid bit;
- `func`, `pc`, `imm`, `insn_tag`;
- per source: ready bit, tag, and value (`XLEN`).

Age ordering and dispatch:
- The station is a collapsing queue: entry 0 is the oldest.
- A new dispatch is written at index `count - issued_this_cycle`, i.e. after compaction.

Select:
- The selected entry is the lowest-index valid entry with both sources ready.
- `issue_en` = a selected entry exists AND `!flush` AND `!reset`.
- `issue_insn` carries the selected entry's fields combinationally. It is all-zero when `issue_en` = 0.

Issue:
- On the clock edge, the issued entry is removed and every higher entry shifts down by one.

Wakeup:
- When `cdb_valid` is high, every valid entry whose source is not ready and whose tag equals `cdb_tag` sets its ready bit and captures `cdb_value` at the edge.

Dispatch capture:
- Accept when `dispatch_valid && dispatch_ready && !flush`.
- If a source is not ready but `cdb_valid` is high and `cdb_tag` equals that source's tag in the same cycle, the source is stored as ready with value `cdb_value`.

Back-pressure:
- `dispatch_ready` = (count < `NUM_ENTRIES`). It is conservative: a same-cycle issue does not free a slot for dispatch.
- `free_count` = `NUM_ENTRIES` − count.

Flush and reset:
- `flush` high clears all valid bits at the edge. A dispatch in the same cycle is dropped.
- Reset has the same effect as flush and has priority over flush.

Arithmetic:
- Tag compares are full `ROB_TAG_LEN`-bit equality.
- Values are never modified, only stored and forwarded.

## Timing
- Reset values: all entries invalid, `issue_en`=0, `issue_insn`=0, `dispatch_ready`=1, `free_count`=`NUM_ENTRIES`.
- Dispatch with both sources ready at edge E0 → `issue_en`=1 in the cycle after E0 (1-cycle latency).
- CDB wakeup in cycle N → entry is eligible in N+1 (without the bypass macro).
- Maximum throughput is 1 issue/cycle. Dispatch and issue can happen in the same cycle.
- Full boundary: with count=`NUM_ENTRIES`, `dispatch_ready`=0 even if an issue happens that cycle. It returns to 1 the cycle after the issue.
- Flush with entries present: `issue_en` is forced to 0 in the flush cycle. The next cycle shows `free_count`=`NUM_ENTRIES` and `issue_en`=0.

## Configuration
- `BRANCH_RS_CDB_BYPASS_EN` defined: an entry whose only missing operand(s) match the current-cycle `cdb_tag` (with `cdb_valid`=1) is eligible for select in that same cycle. `cdb_value` is forwarded into `issue_insn`. Wakeup-to-issue latency is 0 cycles.
- `BRANCH_RS_CDB_BYPASS_EN` undefined: no forwarding into select. Wakeup-to-issue latency is 1 cycle.

## Test plan
- Reset, then dispatch a BEQ with both sources ready (pc=0x100, imm=0x20, tag=5, src1=src2=7) → next cycle `issue_en`=1, `issue_insn.insn_tag`=5, `pc`=0x100, `imm`=0x20, values 7/7; the cycle after that, `free_count`=4.
- Dispatch A (src1 waiting on tag 3), then B (both ready) → B issues first. Broadcast `cdb_tag`=3, value 0x44 → A issues next cycle (same cycle with bypass) with `value_src1`=0x44.
- Dispatch 4 entries, all waiting → `dispatch_ready`=0 and `free_count`=0. Wake entry 2 → it issues, entries 3→2 compact, and `dispatch_ready`=1 one cycle later.
- Dispatch with src2 tag 9 in the same cycle as `cdb_valid`=1, `cdb_tag`=9, value 0xABC → entry stored ready and issues next cycle with `value_src2`=0xABC.
- Three valid entries, two ready; assert `flush` → `issue_en`=0 that cycle, a dispatch that cycle is dropped, and the next cycle shows `free_count`=4 and `issue_en`=0.
- Assert `reset` while full and `flush`=0 → next cycle all outputs are at their reset values.
